paddle_input_ctrl: RTL
======================

Name: paddle_input_ctrl

Overview:
Front-end conditioner for one player's paddle controls. It takes two raw, asynchronous, bouncy push-buttons (up, down) and produces the 2-bit move code consumed directly by the paddle position stage. Codes are 2'b01 = up, 2'b10 = down, 2'b00 = hold. Each move code is a single-cycle pulse, issued once on press and then at a fixed repeat rate while the button is held, so the paddle steps at a controlled speed instead of once per clock.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized input must differ from its stable level before that level flips; must be >= 1.
REPEAT_CYCLES, 416667, cycles between successive move pulses while one direction is held; must be >= 2.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
btn_up_raw  input  1  raw up button; asynchronous to clk; active-high.
btn_down_raw  input  1  raw down button; asynchronous to clk; active-high.
btn  output  2  registered move code to the paddle stage: 01 up pulse, 10 down pulse, 00 otherwise; never 11.
up_level  output  1  debounced up level, registered.
down_level  output  1  debounced down level, registered.

Behaviour:
- Reset (async, no clock edge needed):
  - btn = 00; up_level = 0; down_level = 0.
  - Synchronizers, debounce counters, repeat counter and direction register all cleared; direction = IDLE.
- Synchronizer: two-flop chain per raw input, reset to 0.
- Debounce, per channel:
  - The counter increments on each edge where sync != level.
  - It clears on any edge where sync == level.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync still differs, the level flips and the counter clears.
  - Net effect: the level changes DEBOUNCE_CYCLES+2 rising edges after a clean raw transition.
  - Any raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Direction decode, combinational from the levels: (up, down) = 00 -> IDLE, 10 -> UP, 01 -> DOWN, 11 -> BOTH.
- Direction register: holds the previous cycle's decode. States are IDLE, UP, DOWN, BOTH.
- Pulse generation, registered, evaluated every edge:
  - Entry into UP or DOWN from any other state (including a direct UP<->DOWN switch): btn <= 01 (UP) or 10 (DOWN) on that same edge; repeat counter <= 0. First pulse latency is one edge after the level change.
  - Staying in UP/DOWN: the repeat counter increments. When it equals REPEAT_CYCLES-1, btn <= the direction code and the counter <= 0; otherwise btn <= 00.
  - Result while held: pulses are exactly REPEAT_CYCLES edges apart, each exactly one cycle wide.
  - IDLE or BOTH: btn <= 00; repeat counter held at 0.
  - Leaving BOTH by releasing one button counts as a fresh entry, so it produces an immediate pulse for the remaining direction.
- Repeat counter width is $clog2(REPEAT_CYCLES); it never wraps past REPEAT_CYCLES-1.
- Reset mid-press:
  - Outputs drop to 0 asynchronously.
  - After rst deasserts with a button still held, normal debounce runs, so the first pulse appears DEBOUNCE_CYCLES+3 edges after the first edge with rst low.
- btn never takes the value 11 under any input sequence.

Test Plan:
(Overrides for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8; edges counted from the first edge after the raw change.)
1. Async reset: with up held and pulsing, assert rst between clock edges -> btn=00, up_level=0, down_level=0 before the next edge; all stay 0 while rst=1.
2. Glitch reject: btn_up_raw high for 3 cycles then low -> up_level stays 0 and btn stays 00 for 20 cycles.
3. Held up: btn_up_raw high and held -> up_level=1 at edge 6; btn=01 at edges 7, 15, 23, 31 (single cycle each), 00 on all other edges. Release -> up_level=0 six edges later; no further pulses.
4. Held down: same stimulus on btn_down_raw -> down_level at edge 6; btn=10 at edges 7, 15, 23; never 01 or 11.
5. Both pressed:
   - Hold up until the first pulse; then press down.
   - After down_level rises, btn=00 continuously.
   - Release up -> one edge after up_level falls, btn=10, then again every 8 edges.
6. Direction switch: up_level falls and down_level rises on the same edge (forced by aligned raw edges) -> btn=10 on the next edge with no wait for the repeat period; the repeat counter restarts, so the next 10 comes 8 edges later.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
// Paddle control front end: synchronizes and debounces the up/down buttons,
// then issues single-cycle move pulses on press and at a fixed repeat rate.
module paddle_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 416667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic [1:0] btn,
    output logic       up_level,
    output logic       down_level
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        BOTH = 2'b11
    } dir_t;

    // Bit 0 is the up channel, bit 1 the down channel.
    logic [1:0]         sync_a;
    logic [1:0]         sync_b;
    logic [1:0]         level;
    logic [1:0][DW-1:0] db_cnt;

    dir_t        dir_q;
    dir_t        dir_d;
    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_d;
    logic [1:0]    btn_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            level  <= '0;
            db_cnt <= '0;
        end else begin
            sync_a <= {btn_down_raw, btn_up_raw};
            sync_b <= sync_a;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= IDLE;
            rpt_q <= '0;
            btn   <= '0;
        end else begin
            dir_q <= dir_d;
            rpt_q <= rpt_d;
            btn   <= btn_d;
        end
    end

    // dir_q is last cycle's decode, so any change into UP/DOWN is a fresh entry.
    always_comb begin
        dir_d = IDLE;
        btn_d = '0;
        rpt_d = '0;
        unique case (level)
            2'b00:   dir_d = IDLE;
            2'b01:   dir_d = UP;
            2'b10:   dir_d = DOWN;
            default: dir_d = BOTH;
        endcase
        if (dir_d == UP || dir_d == DOWN) begin
            if (dir_d != dir_q) begin
                btn_d = dir_d;
                rpt_d = '0;
            end else if (rpt_q == RW'(REPEAT_CYCLES - 1)) begin
                btn_d = dir_d;
                rpt_d = '0;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    assign up_level   = level[0];
    assign down_level = level[1];

endmodule
